rx_line_buffer: RTL and testbench

- Receive-side counterpart of the transmit message ROM.
- Captures bytes strobed out of the UART receiver (Bluetooth module → FPGA) into a small RAM until a line terminator (LF 0x0A or CR 0x0D) arrives.
- Then freezes the line and raises line_ready, so downstream logic can read it through a ROM-style address/out_byte port.
- Downstream releases the buffer with line_ack.

---
 rtl/rx_line_buffer_if.sv | 30 +++
 rtl/rx_line_buffer.sv | 99 +++++++++
 tb/tb_rx_line_buffer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rx_line_buffer_if.sv
// Bus bundle for rx_line_buffer: UART byte strobe in, line release in,
// ROM-style read port and line status out.
//
// Handshake: rx_valid is a one-cycle strobe per received byte, and rx_data
// is meaningful only in that cycle. There is no ready/backpressure. Bytes
// that cannot be stored are dropped and flagged through overflow.
// line_ack is a one-cycle pulse that releases a held line.
interface rx_line_buffer_if #(
   parameter int ADDR_W = 5
);
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              line_ack;
   logic [ADDR_W-1:0] rd_add;
   logic [7:0]        out_byte;
   logic              line_ready;
   logic [ADDR_W-1:0] line_len;
   logic              overflow;
   logic              state_dbg;   // 0 = FILL, 1 = READY

   modport master (
      output rx_data, rx_valid, line_ack, rd_add,
      input  out_byte, line_ready, line_len, overflow, state_dbg
   );

   modport slave (
      input  rx_data, rx_valid, line_ack, rd_add,
      output out_byte, line_ready, line_len, overflow, state_dbg
   );
endinterface

// File: rtl/rx_line_buffer.sv
// Receive line buffer. It collects UART bytes into a small RAM until LF or
// CR arrives. It then holds the line for a downstream reader until the
// reader acks the line.
module rx_line_buffer #(
   parameter int         DEPTH  = 16,
   parameter int         ADDR_W = 5,
   parameter logic [7:0] TERM_A = 8'h0A,
   parameter logic [7:0] TERM_B = 8'h0D
) (
   input  logic              clk,
   input  logic              rst,
   rx_line_buffer_if.slave   bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   typedef enum logic {
      FILL  = 1'b0,
      READY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [7:0]        out_byte_q, out_byte_d;
   logic              wr_en;
   logic              is_term;

   logic [7:0] mem [DEPTH];

   assign is_term = (bus.rx_data == TERM_A) || (bus.rx_data == TERM_B);

   // Next-state for the capture FSM, the byte count and the sticky overflow flag.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      case (state_q)
         FILL: begin
            if (bus.rx_valid) begin
               if (is_term) begin
                  // A terminator on an empty line swallows CRLF pairs and blank lines.
                  if (count_q != '0) state_d = READY;
               end else if (count_q < DEPTH_A) begin
                  wr_en   = 1'b1;
                  count_d = count_q + ADDR_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
            end
         end
         READY: begin
            if (bus.line_ack) begin
               state_d = FILL;
               count_d = '0;
               ovf_d   = 1'b0;
            end
            // A byte arriving while a line is held is lost. The set wins over the ack's clear.
            if (bus.rx_valid) ovf_d = 1'b1;
         end
         default: state_d = FILL;
      endcase
   end

   // Read mux. Addresses beyond the RAM read back as zero.
   always_comb begin
      out_byte_d = 8'h00;
      if (bus.rd_add < DEPTH_A) out_byte_d = mem[bus.rd_add[IDX_W-1:0]];
   end

   // Control and read-data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         out_byte_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         out_byte_q <= out_byte_d;
      end
   end

   // Line RAM. It has no reset. A read in the same cycle as a write sees the old contents.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) mem[count_q[IDX_W-1:0]] <= bus.rx_data;
   end

   assign bus.out_byte   = out_byte_q;
   assign bus.line_ready = (state_q == READY);
   assign bus.line_len   = count_q;
   assign bus.overflow   = ovf_q;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_rx_line_buffer.sv
// Testbench for rx_line_buffer. It runs directed line scenarios followed by
// random traffic. All traffic is compared against a line-level model that
// is kept as a byte queue.
module tb_rx_line_buffer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rx_line_buffer_if #(.ADDR_W(5)) bus ();

   rx_line_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: the held/partial line as a queue of bytes, plus RAM knowledge.
   bit         m_ready;
   bit         m_ovf;
   logic [7:0] exp_q[$];
   logic [7:0] m_mem[16];
   bit         m_known[16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_term(input logic [7:0] d);
      return (d == 8'h0A) || (d == 8'h0D);
   endfunction

   // Advances the model by one clock using the line rules.
   task automatic model_step(input bit v, input logic [7:0] d, input bit ack, input bit r);
      if (r) begin
         m_ready = 0;
         m_ovf   = 0;
         exp_q.delete();
      end else if (m_ready) begin
         if (ack) begin
            m_ready = 0;
            m_ovf   = 0;
            exp_q.delete();
         end
         if (v) m_ovf = 1;
      end else if (v) begin
         if (is_term(d)) begin
            if (exp_q.size() > 0) m_ready = 1;
         end else if (exp_q.size() < 16) begin
            m_mem[exp_q.size()]   = d;
            m_known[exp_q.size()] = 1;
            exp_q.push_back(d);
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   // Applies one clock cycle of stimulus, then checks all status outputs and the read data.
   task automatic step(input bit v, input logic [7:0] d, input bit ack, input bit r = 0);
      int         a;
      bit         rd_chk;
      logic [7:0] rd_exp;
      a      = int'(bus.rd_add);
      rd_chk = 1;
      rd_exp = 8'h00;
      if (r || a >= 16) rd_exp = 8'h00;
      else if (m_known[a]) rd_exp = m_mem[a];
      else rd_chk = 0;
      bus.rx_valid = v;
      bus.rx_data  = d;
      bus.line_ack = ack;
      rst          = r;
      @(posedge clk);
      #1;
      bus.rx_valid = 0;
      bus.line_ack = 0;
      rst          = 0;
      model_step(v, d, ack, r);
      chk("line_ready", 32'(bus.line_ready), 32'(m_ready));
      chk("line_len",   32'(bus.line_len),   32'(exp_q.size()));
      chk("overflow",   32'(bus.overflow),   32'(m_ovf));
      chk("state_dbg",  32'(bus.state_dbg),  32'(m_ready));
      if (rd_chk) chk("out_byte", 32'(bus.out_byte), 32'(rd_exp));
   endtask

   task automatic send(input logic [7:0] d);
      step(1, d, 0);
   endtask

   // Reads back every stored byte of the current line through the read port.
   task automatic read_line();
      for (int i = 0; i < exp_q.size(); i++) begin
         bus.rd_add = 5'(i);
         step(0, 8'h00, 0);
         chk("rd_line", 32'(bus.out_byte), 32'(exp_q[i]));
      end
   endtask

   initial begin
      logic [7:0] t1[6] = '{8'h4B, 8'h49, 8'h53, 8'h48, 8'h41, 8'h4E};
      bus.rx_valid = 0;
      bus.rx_data  = 0;
      bus.line_ack = 0;
      bus.rd_add   = 0;
      rst          = 0;
      for (int i = 0; i < 16; i++) m_known[i] = 0;

      // 1: reset, then a plain line terminated by CR
      step(0, 8'h00, 0, 1);
      chk("reset_out_byte", 32'(bus.out_byte), 32'h00);
      chk("reset_len", 32'(bus.line_len), 32'd0);
      foreach (t1[i]) send(t1[i]);
      chk("t1_not_ready_yet", 32'(bus.line_ready), 32'd0);
      send(8'h0D);
      chk("t1_ready", 32'(bus.line_ready), 32'd1);
      chk("t1_len", 32'(bus.line_len), 32'd6);
      chk("t1_ovf", 32'(bus.overflow), 32'd0);
      read_line();
      step(0, 8'h00, 1);

      // 2: leading CRLF is swallowed, and a trailing LF that arrives while READY is dropped
      send(8'h0D); send(8'h0A); send(8'h50); send(8'h41); send(8'h0D);
      chk("t2_len", 32'(bus.line_len), 32'd2);
      read_line();
      send(8'h0A);
      chk("t2_ovf_late_lf", 32'(bus.overflow), 32'd1);
      step(0, 8'h00, 1);
      chk("t2_ack_clears", 32'(bus.overflow), 32'd0);
      send(8'h50); send(8'h41); send(8'h0D);
      step(0, 8'h00, 1);
      send(8'h0A);
      chk("t2_lf_ignored_len", 32'(bus.line_len), 32'd0);
      chk("t2_lf_ignored_ovf", 32'(bus.overflow), 32'd0);

      // 3: overlong line saturates at 16 bytes
      for (int i = 0; i < 18; i++) send(8'(8'h41 + i));
      send(8'h0A);
      chk("t3_len", 32'(bus.line_len), 32'd16);
      chk("t3_ovf", 32'(bus.overflow), 32'd1);
      bus.rd_add = 5'd15;
      step(0, 8'h00, 0);
      chk("t3_mem15", 32'(bus.out_byte), 32'h50);
      read_line();

      // 4: a byte while READY, then ack coinciding with a byte
      send(8'h58);
      chk("t4_len_frozen", 32'(bus.line_len), 32'd16);
      step(1, 8'h59, 1);
      chk("t4_ack_ready", 32'(bus.line_ready), 32'd0);
      chk("t4_ack_ovf_set", 32'(bus.overflow), 32'd1);
      bus.rd_add = 5'd0;
      send(8'h5A);
      step(0, 8'h00, 0);
      chk("t4_5a_at_0", 32'(bus.out_byte), 32'h5A);

      // 5: reset mid-line, then out-of-range reads
      send(8'h41); send(8'h42); send(8'h43);
      step(0, 8'h00, 0, 1);
      send(8'h44); send(8'h0D);
      chk("t5_len", 32'(bus.line_len), 32'd1);
      chk("t5_ovf", 32'(bus.overflow), 32'd0);
      read_line();
      chk("t5_mem0", 32'(bus.out_byte), 32'h44);
      for (int a = 16; a < 32; a++) begin
         bus.rd_add = 5'(a);
         step(0, 8'h00, 0);
      end
      step(0, 8'h00, 1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit         v, ack, r;
         logic [7:0] d;
         bus.rd_add = 5'($urandom_range(0, 31));
         r   = ($urandom_range(0, 299) == 0);
         ack = m_ready && ($urandom_range(0, 3) == 0);
         v   = m_ready ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 12) == 0) d = $urandom_range(0, 1) ? 8'h0A : 8'h0D;
         else d = 8'($urandom_range(32, 126));
         if (m_ready && $urandom_range(0, 3) == 0) read_line();
         step(v, d, ack, r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
